// File: rtl/tetris_2048_input_ctrl.sv
// Player input sequencer: synchronise, debounce and latch raw buttons, then
// issue single-cycle move/drop pulses with a settle lockout and gravity drops.
module tetris_2048_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES    = 6,
  parameter int unsigned AUTO_DROP_CYCLES = 64,
  parameter int unsigned CNT_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_l,
  input  logic       raw_r,
  input  logic       raw_drop,
  input  logic       game_over,
  output logic       btn_l,
  output logic       btn_r,
  output logic       btn_drop,
  output logic       busy,
  output logic       auto_drop_fired,
  output logic [7:0] cmd_count
);

  // Counters "reach" their terminal value on the edge they would step onto it,
  // so the exit compare is made one count early.
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0;
  localparam int unsigned SW          = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned AUTO_LAST   = (AUTO_DROP_CYCLES >= 2) ? AUTO_DROP_CYCLES - 2 : 0;
  localparam bit          AUTO_EN     = (AUTO_DROP_CYCLES != 0);
  localparam int unsigned NB          = 3;  // button index: 0 left, 1 right, 2 drop

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCKOUT, S_OVER} state_t;

  state_t            state_q, state_d;
  logic [NB-1:0]     raw_vec, sync1, sync2, deb, deb_q, rise;
  logic [CNT_W-1:0]  db_cnt [NB];
  logic [NB-1:0]     pend_q, pend_d, pend_clr;
  logic              auto_pend_q, auto_pend_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [NB-1:0]     pulse_d;
  logic              af_d, busy_d;
  logic [7:0]        cnt_d;

  assign raw_vec = {raw_drop, raw_r, raw_l};
  assign rise    = deb & ~deb_q;

  // Two-flop synchroniser, debounce counters and rise-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Arbitration, lockout sequencing, gravity timer and output next values
  always_comb begin
    state_d     = state_q;
    pend_clr    = '0;
    auto_pend_d = auto_pend_q;
    settle_d    = settle_q;
    timer_d     = timer_q;
    pulse_d     = '0;
    af_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (game_over) begin
          state_d = S_OVER;
        end else if (pend_q[2] || auto_pend_q) begin
          pulse_d[2]  = 1'b1;
          af_d        = auto_pend_q;
          pend_clr[2] = 1'b1;
          auto_pend_d = 1'b0;
          state_d     = S_ISSUE;
        end else if (pend_q[0] && pend_q[1]) begin
          pend_clr[1:0] = 2'b11;  // contradictory move is discarded
        end else if (pend_q[0]) begin
          pulse_d[0]  = 1'b1;
          pend_clr[0] = 1'b1;
          state_d     = S_ISSUE;
        end else if (pend_q[1]) begin
          pulse_d[1]  = 1'b1;
          pend_clr[1] = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d  = S_LOCKOUT;
        settle_d = '0;
      end
      S_LOCKOUT: begin
        if (settle_q == SW'(SETTLE_LAST)) begin
          state_d = game_over ? S_OVER : S_IDLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_OVER) begin
      if (pulse_d[2]) begin
        timer_d = '0;
      end else if (AUTO_EN && (timer_q == CNT_W'(AUTO_LAST))) begin
        timer_d     = '0;
        auto_pend_d = 1'b1;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end

    pend_d = (pend_q & ~pend_clr) | rise;
    if (state_d == S_OVER) begin
      pend_d      = '0;
      auto_pend_d = 1'b0;
    end
    busy_d = (state_d == S_LOCKOUT) || (state_d == S_OVER);
    cnt_d  = cmd_count + ((|pulse_d) ? 8'd1 : 8'd0);
  end

  // State, pending requests, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pend_q          <= '0;
      auto_pend_q     <= 1'b0;
      settle_q        <= '0;
      timer_q         <= '0;
      btn_l           <= 1'b0;
      btn_r           <= 1'b0;
      btn_drop        <= 1'b0;
      auto_drop_fired <= 1'b0;
      busy            <= 1'b0;
      cmd_count       <= '0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      auto_pend_q     <= auto_pend_d;
      settle_q        <= settle_d;
      timer_q         <= timer_d;
      btn_l           <= pulse_d[0];
      btn_r           <= pulse_d[1];
      btn_drop        <= pulse_d[2];
      auto_drop_fired <= af_d;
      busy            <= busy_d;
      cmd_count       <= cnt_d;
    end
  end

endmodule
